// File: rtl/debounce_pkg.sv
// Shared types and limits for the input-conditioning blocks.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/debounce_sync_chain.sv
// Plain multi-flop synchronizer for bringing an asynchronous level into clk.
// Kept free of any logic between stages so it can be reused by other
// input-conditioning blocks.
module sync_chain #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rstN,
  input  logic d_async,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift the asynchronous input through the flop chain; reset loads the idle level.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stages <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d_async};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a bouncy asynchronous input, producing a clean
// registered level, single-cycle rise/fall pulses and a busy flag while a
// candidate transition is being qualified.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter int   CNT_W         = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rstN,
  input  logic raw_in,
  input  logic en,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  // The WAIT state is entered with the counter at 1 (the first differing
  // sample already seen), so the move to the opposite stable state happens
  // on the sample that brings the count of differing samples to STABLE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYCLES);
  localparam state_t           RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_sync: SYNC_STAGES must be in 2..4");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2**CNT_W) - 1) begin : g_bad_stable
    $error("debounce_sync: STABLE_CYCLES must be in 1..2**CNT_W-1");
  end

  logic             sync_in;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk     (clk),
    .rstN    (rstN),
    .d_async (raw_in),
    .q       (sync_in)
  );

  // Next-state logic: nothing moves while en is low, including aborts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      STABLE_LOW: begin
        if (en && sync_in) begin
          if (STABLE_CYCLES == 1) begin
            state_nxt = STABLE_HIGH;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WAIT_HIGH;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      WAIT_HIGH: begin
        if (en) begin
          if (!sync_in) begin
            state_nxt = STABLE_LOW;
            cnt_nxt   = '0;
          end else if (cnt >= CNT_LAST) begin
            state_nxt = STABLE_HIGH;
            cnt_nxt   = '0;
          end else if (cnt < CNT_SAT) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      STABLE_HIGH: begin
        if (en && !sync_in) begin
          if (STABLE_CYCLES == 1) begin
            state_nxt = STABLE_LOW;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WAIT_LOW;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      WAIT_LOW: begin
        if (en) begin
          if (sync_in) begin
            state_nxt = STABLE_HIGH;
            cnt_nxt   = '0;
          end else if (cnt >= CNT_LAST) begin
            state_nxt = STABLE_LOW;
            cnt_nxt   = '0;
          end else if (cnt < CNT_SAT) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      default: begin
        state_nxt = RESET_STATE;
        cnt_nxt   = '0;
      end
    endcase
    level_nxt = (state_nxt == STABLE_HIGH) || (state_nxt == WAIT_LOW);
  end

  // State, counter and all outputs are registered; pulses mark a level change at the same edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= RESET_STATE;
      cnt        <= '0;
      level_out  <= RESET_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      level_out  <= level_nxt;
      rise_pulse <= level_nxt & ~level_out;
      fall_pulse <= ~level_nxt & level_out;
      busy       <= (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with default parameters
// (SYNC_STAGES=2, STABLE_CYCLES=4): the level changes 5 edges after the
// first edge that samples the new raw value, busy covers edge offsets 2..4.
module tb_debounce_sync;

  logic clk;
  logic rstN;
  logic raw_in;
  logic en;
  logic level_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  int vecCount  = 0;
  int missCount = 0;

  debounce_sync dut (
    .clk        (clk),
    .rstN       (rstN),
    .raw_in     (raw_in),
    .en         (en),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Runs n edges starting at edge E (the first edge sampling the current raw_in)
  // and checks every output against hand-derived offsets. Negative event
  // offsets disable the corresponding stimulus change.
  task automatic applyStimulus(input string tag, input logic fromLevel, input int n,
                               input int changeAt, input int busyFrom, input int busyTo,
                               input int toggleAt, input int enOffAt, input int enOnAt);
    logic expLevel;
    for (int j = 0; j < n; j++) begin
      tick();
      expLevel = (j >= changeAt) ? ~fromLevel : fromLevel;
      checkOutput($sformatf("%s_level_e%0d", tag, j), 32'(level_out), 32'(expLevel));
      checkOutput($sformatf("%s_rise_e%0d", tag, j), 32'(rise_pulse), 32'((j == changeAt) && !fromLevel));
      checkOutput($sformatf("%s_fall_e%0d", tag, j), 32'(fall_pulse), 32'((j == changeAt) && fromLevel));
      checkOutput($sformatf("%s_busy_e%0d", tag, j), 32'(busy), 32'((j >= busyFrom) && (j < busyTo)));
      if (j == toggleAt) raw_in = ~raw_in;
      if (j == enOffAt)  en = 1'b0;
      if (j == enOnAt)   en = 1'b1;
    end
  endtask

  initial begin
    rstN   = 1'b0;
    raw_in = 1'b1;
    en     = 1'b1;

    // Reset held with raw_in high: everything idle low.
    repeat (3) tick();
    checkOutput("reset_level", 32'(level_out), 32'd0);
    checkOutput("reset_rise", 32'(rise_pulse), 32'd0);
    checkOutput("reset_fall", 32'(fall_pulse), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    // Release with raw_in already high: normal rise debounce.
    rstN = 1'b1;
    applyStimulus("rst_rise", 1'b0, 8, 5, 2, 5, -1, -1, -1);

    // Held low from high level: fall after 5 edges.
    raw_in = 1'b0;
    applyStimulus("fall", 1'b1, 8, 5, 2, 5, -1, -1, -1);

    // 3-cycle high glitch: busy for 3 cycles, no change.
    raw_in = 1'b1;
    applyStimulus("glitch", 1'b0, 9, 1000, 2, 5, 2, -1, -1);

    // Toggle every 2 cycles for 20 cycles: nothing may come through.
    for (int c = 0; c < 20; c++) begin
      raw_in = ((c % 4) < 2) ? 1'b1 : 1'b0;
      tick();
      checkOutput($sformatf("toggle_level_c%0d", c), 32'(level_out), 32'd0);
      checkOutput($sformatf("toggle_rise_c%0d", c), 32'(rise_pulse), 32'd0);
      checkOutput($sformatf("toggle_fall_c%0d", c), 32'(fall_pulse), 32'd0);
    end
    raw_in = 1'b1;
    applyStimulus("toggle_hold", 1'b0, 8, 5, 2, 5, -1, -1, -1);

    // Back low, then a rise with en dropped for 3 edges after counter=2.
    raw_in = 1'b0;
    applyStimulus("fall2", 1'b1, 8, 5, 2, 5, -1, -1, -1);
    raw_in = 1'b1;
    applyStimulus("en_hold", 1'b0, 11, 8, 2, 8, -1, 3, 6);

    // Back low, then reset asynchronously mid WAIT_HIGH.
    raw_in = 1'b0;
    applyStimulus("fall3", 1'b1, 8, 5, 2, 5, -1, -1, -1);
    raw_in = 1'b1;
    for (int j = 0; j < 5; j++) tick();
    checkOutput("midwait_busy", 32'(busy), 32'd1);
    checkOutput("midwait_level", 32'(level_out), 32'd0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_rst_level", 32'(level_out), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_rise", 32'(rise_pulse), 32'd0);
    repeat (2) tick();
    checkOutput("rst_hold_level", 32'(level_out), 32'd0);
    checkOutput("rst_hold_rise", 32'(rise_pulse), 32'd0);
    rstN = 1'b1;
    applyStimulus("rst_rerise", 1'b0, 8, 5, 2, 5, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
